regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (we3/wa3/wd3) between two writeback requesters.
  - Requester A: ALU/EX result.
  - Requester B: memory load result.
- Each requester has a one-entry holding slot with valid/ready handshake.
- Arbitration is round-robin, with age ordering when both slots target the same register.
- Exports a pending-write scoreboard so the decode stage can stall on read-after-write hazards.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/wb_slot.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 101 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;
    localparam logic [ADDR_W-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} grant_t;

    function automatic logic [NREGS-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
        return NREGS'(1) << a;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot: captures on valid&ready, empties when granted.
// A captured XZR write never requests the port and drains on the following edge.
module wb_slot
    import regfile_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    in_valid,
    output logic    in_ready,
    input  wb_req_t in_req,
    input  logic    grant,
    output logic    capture,
    output logic    active,
    output wb_req_t req
);

    logic    full;
    wb_req_t held;

    // Handshake: transfer on the rising edge when in_valid & in_ready; a granted
    // slot frees itself that same edge, so it may accept a new write back-to-back.
    assign in_ready = ~full | grant;
    assign capture  = in_valid & in_ready;
    assign active   = full & (held.addr != XZR);
    assign req      = held;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= 1'b0;
            held <= '0;
        end else if (capture) begin
            full <= 1'b1;
            held <= in_req;
        end else if (grant || (full && held.addr == XZR)) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between EX (A) and MEM (B).
// Optional macro REGFILE_WB_FWD_EN adds combinational bypass ports off the write port.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic [NREGS-1:0]  pend_mask
`ifdef REGFILE_WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data
`endif
);

    wb_req_t a_req, b_req;
    logic    a_cap, b_cap, a_act, b_act;
    grant_t  gnt;
    logic    two_way;
    logic    rr_b;     // 1: B preferred on the next two-way grant
    logic    b_older;  // 1: B slot holds the older write

    wb_slot u_slot_a (
        .clk(clk), .reset_n(reset_n), .in_valid(a_valid), .in_ready(a_ready),
        .in_req('{addr: a_addr, data: a_data}), .grant(gnt == GNT_A),
        .capture(a_cap), .active(a_act), .req(a_req)
    );

    wb_slot u_slot_b (
        .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_req('{addr: b_addr, data: b_data}), .grant(gnt == GNT_B),
        .capture(b_cap), .active(b_act), .req(b_req)
    );

    always_comb begin
        gnt     = GNT_NONE;
        two_way = 1'b0;
        if (a_act && b_act) begin
            if (a_req.addr == b_req.addr) begin
                gnt = b_older ? GNT_B : GNT_A;
            end else begin
                two_way = 1'b1;
                gnt     = rr_b ? GNT_B : GNT_A;
            end
        end else if (a_act) begin
            gnt = GNT_A;
        end else if (b_act) begin
            gnt = GNT_B;
        end
    end

    // A fresh capture in A makes B the older entry; same-edge captures also leave
    // B older, since MEM carries the earlier instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_b    <= 1'b0;
            b_older <= 1'b0;
            we3     <= 1'b0;
            wa3     <= '0;
            wd3     <= '0;
        end else begin
            rr_b    <= rr_b ^ two_way;
            b_older <= a_cap ? 1'b1 : (b_cap ? 1'b0 : b_older);
            we3     <= (gnt != GNT_NONE);
            if (gnt == GNT_A) begin
                wa3 <= a_req.addr;
                wd3 <= a_req.data;
            end else if (gnt == GNT_B) begin
                wa3 <= b_req.addr;
                wd3 <= b_req.data;
            end
        end
    end

    assign pend_mask = (a_act ? addr_onehot(a_req.addr) : '0)
                     | (b_act ? addr_onehot(b_req.addr) : '0)
                     | (we3   ? addr_onehot(wa3)        : '0);

`ifdef REGFILE_WB_FWD_EN
    assign fwd1_hit  = we3 && (wa3 == ra1) && (ra1 != XZR);
    assign fwd2_hit  = we3 && (wa3 == ra2) && (ra2 != XZR);
    assign fwd1_data = wd3;
    assign fwd2_data = wd3;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed cases plus randomized traffic against a
// slot/timestamp model; honours REGFILE_WB_FWD_EN when defined.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              a_valid = 1'b0, b_valid = 1'b0;
    logic              a_ready, b_ready;
    logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0] a_data = '0, b_data = '0;
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;
    logic [NREGS-1:0]  pend_mask;
`ifdef REGFILE_WB_FWD_EN
    logic [ADDR_W-1:0] ra1 = '0, ra2 = '0;
    logic              fwd1_hit, fwd2_hit;
    logic [DATA_W-1:0] fwd1_data, fwd2_data;
`endif

    regfile_wb_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .we3(we3), .wa3(wa3), .wd3(wd3), .pend_mask(pend_mask)
`ifdef REGFILE_WB_FWD_EN
        , .ra1(ra1), .ra2(ra2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- register file fed by the DUT write port ----------------
    logic [DATA_W-1:0] rf_dut [NREGS];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) rf_dut[i] <= '0;
        end else if (we3) begin
            rf_dut[wa3] <= wd3;
        end
    end

    // ---------------- behavioural model ----------------
    // Slots carry capture timestamps; smaller stamp = older write.
    logic              m_v    [2];
    logic [ADDR_W-1:0] m_addr [2];
    logic [DATA_W-1:0] m_data [2];
    int unsigned       m_seq  [2];
    int                m_pref;
    logic              m_we;
    logic [ADDR_W-1:0] m_wa;
    logic [DATA_W-1:0] m_wd;
    logic [DATA_W-1:0] m_rf [NREGS];
    int unsigned       stamp;

    function automatic bit m_req(input int i);
        return m_v[i] && (m_addr[i] != XZR);
    endfunction

    function automatic int m_pick();
        if (m_req(0) && m_req(1)) begin
            if (m_addr[0] == m_addr[1]) return (m_seq[1] < m_seq[0]) ? 1 : 0;
            return m_pref;
        end
        if (m_req(0)) return 0;
        if (m_req(1)) return 1;
        return -1;
    endfunction

    function automatic logic [NREGS-1:0] m_pend();
        logic [NREGS-1:0] p = '0;
        for (int i = 0; i < 2; i++) if (m_req(i)) p[m_addr[i]] = 1'b1;
        if (m_we) p[m_wa] = 1'b1;
        return p;
    endfunction

    function automatic bit m_ready(input int i);
        return !m_v[i] || (m_pick() == i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; m_seq[i] = 0;
        end
        for (int r = 0; r < NREGS; r++) m_rf[r] = '0;
        m_pref = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; stamp = 0;
    endtask

    task automatic model_step();
        int g;
        bit acc_a, acc_b;
        g     = m_pick();
        acc_a = a_valid && m_ready(0);
        acc_b = b_valid && m_ready(1);
        if (m_we) m_rf[m_wa] = m_wd;
        if (m_req(0) && m_req(1) && m_addr[0] != m_addr[1]) m_pref ^= 1;
        if (g >= 0) begin
            m_we = 1'b1; m_wa = m_addr[g]; m_wd = m_data[g];
            m_v[g] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        for (int i = 0; i < 2; i++) if (m_v[i] && m_addr[i] == XZR) m_v[i] = 1'b0;
        stamp += 2;
        if (acc_a) begin m_v[0] = 1'b1; m_addr[0] = a_addr; m_data[0] = a_data; m_seq[0] = stamp + 1; end
        if (acc_b) begin m_v[1] = 1'b1; m_addr[1] = b_addr; m_data[1] = b_data; m_seq[1] = stamp; end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            chk("we3", 64'(we3), 64'(m_we));
            if (m_we) begin
                chk("wa3", 64'(wa3), 64'(m_wa));
                chk("wd3", wd3, m_wd);
            end
            chk("pend_mask", 64'(pend_mask), 64'(m_pend()));
            chk("a_ready", 64'(a_ready), 64'(m_ready(0)));
            chk("b_ready", 64'(b_ready), 64'(m_ready(1)));
`ifdef REGFILE_WB_FWD_EN
            chk("fwd1_hit", 64'(fwd1_hit), 64'(m_we && m_wa == ra1 && ra1 != XZR));
            chk("fwd2_hit", 64'(fwd2_hit), 64'(m_we && m_wa == ra2 && ra2 != XZR));
            if (m_we) chk("fwd1_data", fwd1_data, m_wd);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset_n) model_reset();
        else model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
        a_valid = v; a_addr = ad; a_data = d;
    endtask

    task automatic drive_b(input logic v, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
        b_valid = v; b_addr = ad; b_data = d;
    endtask

    initial begin
        int r;
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_wa3", 64'(wa3), 64'd0);
        chk("rst_wd3", wd3, 64'd0);
        chk("rst_pend", 64'(pend_mask), 64'd0);
        chk("rst_a_ready", 64'(a_ready), 64'd1);

        // A only, addr 5
        drive_a(1'b1, 5'd5, 64'hAA);
        tick();
        drive_a(1'b0, '0, '0);
        chk("a5_pend_after_accept", 64'(pend_mask), 64'h20);
        chk("a5_we3_low_first", 64'(we3), 64'd0);
        tick();
        chk("a5_we3", 64'(we3), 64'd1);
        chk("a5_wa3", 64'(wa3), 64'd5);
        chk("a5_wd3", wd3, 64'hAA);
        chk("a5_pend_on_port", 64'(pend_mask), 64'h20);
        tick();
        chk("a5_we3_drop", 64'(we3), 64'd0);
        chk("a5_pend_clear", 64'(pend_mask), 64'd0);
        chk("a5_wa3_hold", 64'(wa3), 64'd5);

        // A addr 3 and B addr 4 on the same edge: pointer starts at A
        drive_a(1'b1, 5'd3, 64'h33);
        drive_b(1'b1, 5'd4, 64'h44);
        tick();
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        chk("pair_pend", 64'(pend_mask), 64'h18);
        tick();
        chk("pair_first_wa3", 64'(wa3), 64'd3);
        tick();
        chk("pair_second_we3", 64'(we3), 64'd1);
        chk("pair_second_wa3", 64'(wa3), 64'd4);
        tick();

        // Same register from both: B (older) first, A last
        drive_a(1'b1, 5'd7, 64'h11);
        drive_b(1'b1, 5'd7, 64'h22);
        tick();
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        tick();
        chk("same_first_wd3", wd3, 64'h22);
        tick();
        chk("same_second_wd3", wd3, 64'h11);
        tick();
        chk("same_final_x7", rf_dut[7], 64'h11);

        // XZR write: accepted, never reaches the port
        drive_a(1'b1, XZR, 64'hFF);
        tick();
        drive_a(1'b0, '0, '0);
        chk("xzr_pend", 64'(pend_mask), 64'd0);
        chk("xzr_ready_busy", 64'(a_ready), 64'd0);
        tick();
        chk("xzr_we3", 64'(we3), 64'd0);
        chk("xzr_ready_free", 64'(a_ready), 64'd1);

`ifdef REGFILE_WB_FWD_EN
        drive_a(1'b1, 5'd9, 64'h55);
        tick();
        drive_a(1'b0, '0, '0);
        tick();
        ra1 = 5'd9;
        ra2 = XZR;
        #1;
        chk("fwd1_hit_lit", 64'(fwd1_hit), 64'd1);
        chk("fwd1_data_lit", fwd1_data, 64'h55);
        chk("fwd2_hit_xzr", 64'(fwd2_hit), 64'd0);
        tick();
`endif

        // Reset while a write is on the port and a slot is still full
        drive_a(1'b1, 5'd10, 64'hA0);
        drive_b(1'b1, 5'd11, 64'hB0);
        tick();
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        tick();
        chk("pre_rst_we3", 64'(we3), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_we3", 64'(we3), 64'd0);
        chk("async_rst_pend", 64'(pend_mask), 64'd0);
        chk("async_rst_wa3", 64'(wa3), 64'd0);
        model_reset();
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_we3", 64'(we3), 64'd0);
        chk("post_rst_pend", 64'(pend_mask), 64'd0);

        // Randomized traffic, biased toward address collisions and XZR
        for (int c = 0; c < 800; c++) begin
            r = $urandom_range(0, 7);
            drive_a($urandom_range(0, 99) < 60,
                    (r < 3) ? ADDR_W'(r) : (r == 3) ? XZR : ADDR_W'($urandom_range(0, 31)),
                    {$urandom, $urandom});
            r = $urandom_range(0, 7);
            drive_b($urandom_range(0, 99) < 60,
                    (r < 3) ? ADDR_W'(r) : (r == 3) ? XZR : ADDR_W'($urandom_range(0, 31)),
                    {$urandom, $urandom});
`ifdef REGFILE_WB_FWD_EN
            ra1 = ADDR_W'($urandom_range(0, 31));
            ra2 = ADDR_W'($urandom_range(0, 3));
`endif
            tick();
        end
        drive_a(1'b0, '0, '0);
        drive_b(1'b0, '0, '0);
        repeat (4) tick();
        for (int i = 0; i < NREGS; i++) chk($sformatf("rf_x%0d", i), rf_dut[i], m_rf[i]);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
